// File: rtl/single_ch_fifo_reader.sv
// Read-side controller for a single-channel FIFO with 1-cycle read latency.
// Prefetches words into a small buffer and presents them as a valid/ready stream.
module single_ch_fifo_reader #(
  parameter int DW      = 32,
  parameter int BUF_LOG = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          EMPTY,
  output logic          DEQ,
  input  logic [DW-1:0] FIFO_DOT,
  output logic [DW-1:0] DOT,
  output logic          DOT_VLD,
  input  logic          DOT_RDY,
  output logic [31:0]   RCNT
);

  localparam int DEPTH = 1 << BUF_LOG;

  logic [DW-1:0]      buf_mem [DEPTH];
  logic               inflight_q;
  logic [BUF_LOG:0]   cnt_q;
  logic [BUF_LOG-1:0] head_q;
  logic [BUF_LOG-1:0] tail_q;
  logic [31:0]        rcnt_q;
  logic [BUF_LOG+1:0] occupancy;
  logic               pop;

  // A read is only issued if its word is guaranteed a free slot on arrival,
  // counting the word still in flight; this keeps DEQ independent of DOT_RDY.
  assign occupancy = {1'b0, cnt_q} + {{(BUF_LOG+1){1'b0}}, inflight_q};
  assign DEQ       = EN & ~EMPTY & ~RST & (occupancy < (BUF_LOG+2)'(DEPTH));

  assign DOT_VLD = ~RST & (cnt_q != '0);
  assign DOT     = buf_mem[head_q];
  assign pop     = DOT_VLD & DOT_RDY;
  assign RCNT    = rcnt_q;

  always_ff @(posedge CLK) begin
    if (inflight_q && !RST) begin
      buf_mem[tail_q] <= FIFO_DOT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      rcnt_q     <= '0;
    end else begin
      inflight_q <= DEQ;
      if (inflight_q) begin
        tail_q <= tail_q + BUF_LOG'(1);
      end
      if (pop) begin
        head_q <= head_q + BUF_LOG'(1);
        rcnt_q <= rcnt_q + 32'd1;
      end
      case ({inflight_q, pop})
        2'b10:   cnt_q <= cnt_q + (BUF_LOG+1)'(1);
        2'b01:   cnt_q <= cnt_q - (BUF_LOG+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_single_ch_fifo_reader.sv
// Scoreboard bench for single_ch_fifo_reader: a FIFO model supplies known words,
// a monitor pops the expected queue on each output handshake.
module tb_single_ch_fifo_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        EMPTY;
  logic        DEQ;
  logic [31:0] FIFO_DOT;
  logic [31:0] DOT;
  logic        DOT_VLD;
  logic        DOT_RDY;
  logic [31:0] RCNT;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] next_val = 32'd0;
  logic [31:0] pops_model = 32'd0;
  logic        hold_pending = 1'b0;
  logic [31:0] held_dot = 32'd0;

  single_ch_fifo_reader #(.DW(32), .BUF_LOG(2)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .EMPTY(EMPTY), .DEQ(DEQ),
    .FIFO_DOT(FIFO_DOT), .DOT(DOT), .DOT_VLD(DOT_VLD), .DOT_RDY(DOT_RDY),
    .RCNT(RCNT)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic en, input logic empty, input logic rdy);
    @(posedge CLK);
    #1;
    RST = rst; EN = en; EMPTY = empty; DOT_RDY = rdy;
    @(negedge CLK);
  endtask

  // FIFO model: a read strobe seen this cycle yields the next word on FIFO_DOT next cycle.
  always begin : fifo_model
    logic d;
    @(negedge CLK);
    d = DEQ;
    @(posedge CLK);
    #1;
    if (d === 1'b1) begin
      FIFO_DOT = next_val;
      exp_q.push_back(next_val);
      next_val = next_val + 32'd1;
    end
  end

  always @(negedge CLK) begin : monitor
    if (RST === 1'b1) begin
      check_output("vld_in_reset", {31'd0, DOT_VLD}, 32'd0);
      check_output("deq_in_reset", {31'd0, DEQ}, 32'd0);
      exp_q.delete();
      pops_model   = 32'd0;
      hold_pending = 1'b0;
    end else begin
      check_output("rcnt", RCNT, pops_model);
      check_output("no_underflow", {31'd0, DEQ & EMPTY}, 32'd0);
      if (hold_pending) begin
        check_output("hold_vld", {31'd0, DOT_VLD}, 32'd1);
        check_output("hold_dot", DOT, held_dot);
      end
      if (DOT_VLD && DOT_RDY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", DOT);
        end else begin
          check_output("dot_order", DOT, exp_q.pop_front());
        end
        pops_model = pops_model + 32'd1;
      end
      hold_pending = DOT_VLD && !DOT_RDY;
      held_dot     = DOT;
    end
  end

  initial begin
    int dq;
    RST = 1'b1; EN = 1'b0; EMPTY = 1'b1; DOT_RDY = 1'b0; FIFO_DOT = 32'd0;

    // reset holds DEQ and DOT_VLD low even with a non-empty FIFO
    apply_stimulus(1, 1, 0, 1);
    apply_stimulus(1, 1, 0, 1);
    check_output("rst_deq", {31'd0, DEQ}, 32'd0);
    check_output("rst_vld", {31'd0, DOT_VLD}, 32'd0);
    apply_stimulus(0, 0, 1, 1);
    check_output("rst_rcnt", RCNT, 32'd0);
    check_output("rst_vld_after", {31'd0, DOT_VLD}, 32'd0);

    // single word, two-cycle latency
    next_val = 32'h5;
    apply_stimulus(0, 1, 0, 1);
    check_output("single_deq", {31'd0, DEQ}, 32'd1);
    apply_stimulus(0, 1, 1, 1);
    check_output("single_deq_off", {31'd0, DEQ}, 32'd0);
    check_output("single_vld_n1", {31'd0, DOT_VLD}, 32'd0);
    apply_stimulus(0, 1, 1, 1);
    check_output("single_vld_n2", {31'd0, DOT_VLD}, 32'd1);
    check_output("single_dot", DOT, 32'h5);
    apply_stimulus(0, 1, 1, 1);
    check_output("single_rcnt", RCNT, 32'd1);
    check_output("single_vld_n3", {31'd0, DOT_VLD}, 32'd0);

    // streaming at full throughput
    apply_stimulus(1, 1, 1, 1);
    next_val = 32'd0;
    for (int i = 0; i < 1000; i++) begin
      apply_stimulus(0, 1, 0, 1);
      check_output("stream_deq", {31'd0, DEQ}, 32'd1);
      if (i >= 2) begin
        check_output("stream_vld", {31'd0, DOT_VLD}, 32'd1);
        check_output("stream_dot", DOT, 32'(i - 2));
      end
    end
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 1, 1);
    check_output("stream_rcnt", RCNT, 32'd1000);
    check_output("stream_drained", {31'd0, DOT_VLD}, 32'd0);

    // backpressure: four reads fill the buffer, then drain in order
    apply_stimulus(1, 1, 1, 0);
    next_val = 32'h200;
    dq = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, 1, 0, 0);
      dq += int'(DEQ);
      if (i >= 2) begin
        check_output("bp_vld", {31'd0, DOT_VLD}, 32'd1);
        check_output("bp_dot_hold", DOT, 32'h200);
      end
    end
    check_output("bp_deq_count", 32'(dq), 32'd4);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 1, 1, 1);
      if (i < 4) begin
        check_output("bp_drain_vld", {31'd0, DOT_VLD}, 32'd1);
        check_output("bp_drain_dot", DOT, 32'h200 + 32'(i));
      end else begin
        check_output("bp_drain_done", {31'd0, DOT_VLD}, 32'd0);
        check_output("bp_rcnt", RCNT, 32'd4);
      end
    end

    // empty / disabled: no reads; an in-flight word survives EN dropping
    apply_stimulus(1, 1, 1, 1);
    dq = 0;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(0, 1, 1, 1);
      dq += int'(DEQ);
    end
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(0, 0, 0, 1);
      dq += int'(DEQ);
    end
    check_output("idle_deq_count", 32'(dq), 32'd0);
    next_val = 32'h300;
    apply_stimulus(0, 1, 0, 1);
    check_output("en_drop_deq", {31'd0, DEQ}, 32'd1);
    apply_stimulus(0, 0, 0, 1);
    check_output("en_drop_no_deq", {31'd0, DEQ}, 32'd0);
    apply_stimulus(0, 0, 0, 1);
    check_output("en_drop_vld", {31'd0, DOT_VLD}, 32'd1);
    check_output("en_drop_dot", DOT, 32'h300);
    apply_stimulus(0, 0, 0, 1);
    check_output("en_drop_done", {31'd0, DOT_VLD}, 32'd0);

    // reset with three buffered words discards them
    apply_stimulus(1, 1, 1, 0);
    next_val = 32'h400;
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 1, 1, 0);
    apply_stimulus(0, 1, 1, 0);
    check_output("mid_vld_before", {31'd0, DOT_VLD}, 32'd1);
    apply_stimulus(1, 1, 1, 0);
    apply_stimulus(0, 1, 1, 1);
    check_output("mid_vld_after", {31'd0, DOT_VLD}, 32'd0);
    check_output("mid_rcnt_after", RCNT, 32'd0);
    check_output("mid_deq_after", {31'd0, DEQ}, 32'd0);
    next_val = 32'h500;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 1, 0, 1);
      if (i >= 2) check_output("mid_restart_dot", DOT, 32'h500 + 32'(i - 2));
    end
    for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 1, 1);
    check_output("mid_restart_rcnt", RCNT, 32'd6);

    // random traffic against the scoreboard
    next_val = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 4) < 3));
    end
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !DOT_VLD && !DEQ) break;
      apply_stimulus(0, 0, 1, 1);
    end
    check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check_output("final_rcnt", RCNT, pops_model);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
